// File: rtl/music_prod_accum_if.sv
// Stream interface for the MUSIC product accumulator.
// Carries the product input stream and the packet-sum output stream.
// The slave modport is the accumulator side. The master modport is the producer/consumer side.
interface music_prod_accum_if #(
  parameter int DIN_WIDTH  = 15,
  parameter int DOUT_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic signed [DIN_WIDTH-1:0]  prod_tdata;
  logic                         prod_tvalid;
  logic                         prod_tlast;
  logic                         prod_tready;
  logic signed [DOUT_WIDTH-1:0] sum_tdata;
  logic [CNT_WIDTH-1:0]         sum_tcnt;
  logic                         sum_ovf;
  logic                         sum_tvalid;
  logic                         sum_tready;

  modport slave (
    input  prod_tdata, prod_tvalid, prod_tlast, sum_tready,
    output prod_tready, sum_tdata, sum_tcnt, sum_ovf, sum_tvalid
  );

  modport master (
    output prod_tdata, prod_tvalid, prod_tlast, sum_tready,
    input  prod_tready, sum_tdata, sum_tcnt, sum_ovf, sum_tvalid
  );
endinterface

// File: rtl/music_prod_accum.sv
// MUSIC product accumulator.
// Sums a tlast-delimited packet of signed products into a wide accumulator.
// It then emits the result once per packet: scaled, saturated, with the beat count and a wrap flag.
// Optional macro MUSIC_PROD_ACCUM_ROUND_EN adds round-half-up before the scaling shift.
// Without the macro, the shift is a plain floor.
// The interface widths must match DIN_WIDTH/DOUT_WIDTH/CNT_WIDTH.
module music_prod_accum #(
  parameter int DIN_WIDTH  = 15,
  parameter int ACC_WIDTH  = 24,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 2,
  parameter int CNT_WIDTH  = 8
) (
  input logic               ap_clk,
  input logic               ap_rst,
  music_prod_accum_if.slave bus
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Saturation bounds, expressed at the pre-shift width (ACC_WIDTH+1).
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+2){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

`ifdef MUSIC_PROD_ACCUM_ROUND_EN
  localparam int RND_INT = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(RND_INT);
`endif

  logic [0:0]                   state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         ovf_q, ovf_d;
  logic signed [DOUT_WIDTH-1:0] sum_data_q, sum_data_d;
  logic [CNT_WIDTH-1:0]         sum_cnt_q, sum_cnt_d;
  logic                         sum_ovf_q, sum_ovf_d;
  logic                         sum_vld_q, sum_vld_d;

  logic signed [ACC_WIDTH-1:0]  din_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic                         add_ovf;
  logic [CNT_WIDTH-1:0]         cnt_inc;
  logic signed [ACC_WIDTH:0]    pre_shift;
  logic signed [ACC_WIDTH:0]    shifted;
  logic signed [DOUT_WIDTH-1:0] sat_val;
  logic                         beat;

  // Datapath: running sum including the current beat, its wrap detect, and the scaled/saturated result.
  always_comb begin
    din_ext   = {{(ACC_WIDTH-DIN_WIDTH){bus.prod_tdata[DIN_WIDTH-1]}}, bus.prod_tdata};
    acc_sum   = acc_q + din_ext;
    add_ovf   = (acc_q[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
                (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // One extra bit of headroom, so the rounding add cannot wrap.
    pre_shift = {acc_sum[ACC_WIDTH-1], acc_sum};
`ifdef MUSIC_PROD_ACCUM_ROUND_EN
    pre_shift = pre_shift + RND;
`endif
    shifted   = pre_shift >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_val = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
    else                        sat_val = shifted[DOUT_WIDTH-1:0];
    beat      = (state_q == ST_ACCUM) && bus.prod_tvalid;
  end

  // Control: accumulate in ACCUM, publish on tlast, then park in HOLD until the result is taken.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    sum_data_d = sum_data_q;
    sum_cnt_d  = sum_cnt_q;
    sum_ovf_d  = sum_ovf_q;
    sum_vld_d  = sum_vld_q;
    if (state_q == ST_ACCUM) begin
      if (beat) begin
        if (bus.prod_tlast) begin
          sum_data_d = sat_val;
          sum_cnt_d  = cnt_inc;
          sum_ovf_d  = ovf_q | add_ovf;
          sum_vld_d  = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          state_d    = ST_HOLD;
        end else begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
        end
      end
    end else if (bus.sum_tready) begin
      sum_vld_d = 1'b0;
      state_d   = ST_ACCUM;
    end
  end

  // State registers with synchronous reset; a reset drops any partial packet.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= ST_ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      sum_data_q <= '0;
      sum_cnt_q  <= '0;
      sum_ovf_q  <= 1'b0;
      sum_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      sum_data_q <= sum_data_d;
      sum_cnt_q  <= sum_cnt_d;
      sum_ovf_q  <= sum_ovf_d;
      sum_vld_q  <= sum_vld_d;
    end
  end

  assign bus.prod_tready = (state_q == ST_ACCUM);
  assign bus.sum_tdata   = sum_data_q;
  assign bus.sum_tcnt    = sum_cnt_q;
  assign bus.sum_ovf     = sum_ovf_q;
  assign bus.sum_tvalid  = sum_vld_q;

endmodule

// File: tb/tb_music_prod_accum.sv
// Testbench for music_prod_accum.
// Table-driven packets, plus hand-written sequences for the following:
// - backpressure
// - tlast with tvalid low
// - mid-packet reset
module tb_music_prod_accum;
  localparam int DW = 15;
`ifdef MUSIC_PROD_ACCUM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  music_prod_accum_if #(.DIN_WIDTH(15), .DOUT_WIDTH(16), .CNT_WIDTH(8)) bus ();

  music_prod_accum #(
    .DIN_WIDTH(15), .ACC_WIDTH(24), .DOUT_WIDTH(16), .SHIFT(2), .CNT_WIDTH(8)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus(bus)
  );

  typedef struct {
    int v0; int n0;
    int v1; int n1;
    int v2; int n2;
    int d_flr; int d_rnd;
    int cnt;
    int ovf;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic beat(input int v, input bit last);
    int k;
    bus.prod_tdata  = DW'(v);
    bus.prod_tvalid = 1'b1;
    bus.prod_tlast  = last;
    k = 0;
    while (!bus.prod_tready && k < 20) begin
      @(negedge ap_clk);
      k++;
    end
    if (k == 20) chk("beat_accept_timeout", 0, 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
  endtask

  // Called on the negedge right after the loading edge; checks the result, then completes the handshake.
  task automatic expect_result(input string name, input int d, input int c, input int o);
    chk({name, ".tvalid"}, int'(bus.sum_tvalid), 1);
    chk({name, ".tdata"},  int'($signed(bus.sum_tdata)), d);
    chk({name, ".tcnt"},   int'(bus.sum_tcnt), c);
    chk({name, ".ovf"},    int'(bus.sum_ovf), o);
    bus.sum_tready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.sum_tready = 1'b0;
    chk({name, ".tvalid_drop"}, int'(bus.sum_tvalid), 0);
    chk({name, ".tready_back"}, int'(bus.prod_tready), 1);
  endtask

  vec_t vecs[10];

  initial begin
    int total, idx, vv, nn;

    vecs[0] = '{100, 1, 200, 1, -50, 1, 62, 63, 3, 0};
    vecs[1] = '{-5, 1, 0, 0, 0, 0, -2, -1, 1, 0};
    vecs[2] = '{16383, 300, 0, 0, 0, 0, 32767, 32767, 255, 0};
    vecs[3] = '{-16384, 300, 0, 0, 0, 0, -32768, -32768, 255, 0};
    vecs[4] = '{16383, 600, 0, 0, 0, 0, -32768, -32768, 255, 1};
    vecs[5] = '{1000, 4, 0, 0, 0, 0, 1000, 1000, 4, 0};
    vecs[6] = '{7, 1, 0, 0, 0, 0, 1, 2, 1, 0};
    vecs[7] = '{-7, 1, 0, 0, 0, 0, -2, -2, 1, 0};
    vecs[8] = '{16383, 8, 4, 1, 0, 0, 32767, 32767, 9, 0};
    vecs[9] = '{-16384, 8, -1, 1, 0, 0, -32768, -32768, 9, 0};

    bus.prod_tdata  = '0;
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
    bus.sum_tready  = 1'b0;
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("rst.tready", int'(bus.prod_tready), 1);
    chk("rst.tvalid", int'(bus.sum_tvalid), 0);
    chk("rst.tdata",  int'($signed(bus.sum_tdata)), 0);
    chk("rst.tcnt",   int'(bus.sum_tcnt), 0);
    chk("rst.ovf",    int'(bus.sum_ovf), 0);

    for (int i = 0; i < 10; i++) begin
      total = vecs[i].n0 + vecs[i].n1 + vecs[i].n2;
      idx = 0;
      for (int s = 0; s < 3; s++) begin
        vv = (s == 0) ? vecs[i].v0 : (s == 1) ? vecs[i].v1 : vecs[i].v2;
        nn = (s == 0) ? vecs[i].n0 : (s == 1) ? vecs[i].n1 : vecs[i].n2;
        for (int j = 0; j < nn; j++) begin
          idx++;
          beat(vv, idx == total);
        end
      end
      expect_result($sformatf("vec%0d", i), RND ? vecs[i].d_rnd : vecs[i].d_flr,
                    vecs[i].cnt, vecs[i].ovf);
    end

    // Backpressure: a result held for 5 cycles while a product waits; nothing may be taken.
    beat(40, 1'b1);
    chk("hold.first_valid", int'(bus.sum_tvalid), 1);
    bus.prod_tdata  = DW'(555);
    bus.prod_tvalid = 1'b1;
    bus.prod_tlast  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      chk($sformatf("hold%0d.tready", c), int'(bus.prod_tready), 0);
      chk($sformatf("hold%0d.tvalid", c), int'(bus.sum_tvalid), 1);
      chk($sformatf("hold%0d.tdata", c), int'($signed(bus.sum_tdata)), 10);
      chk($sformatf("hold%0d.tcnt", c), int'(bus.sum_tcnt), 1);
    end
    bus.sum_tready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.sum_tready = 1'b0;
    chk("hold.release_tvalid", int'(bus.sum_tvalid), 0);
    chk("hold.release_tready", int'(bus.prod_tready), 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.prod_tvalid = 1'b0;
    bus.prod_tlast  = 1'b0;
    expect_result("hold_next", RND ? 139 : 138, 1, 0);

    // tlast while tvalid is low must not end the packet.
    beat(10, 1'b0);
    bus.prod_tlast = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    bus.prod_tlast = 1'b0;
    chk("idle_last.tvalid", int'(bus.sum_tvalid), 0);
    beat(20, 1'b1);
    expect_result("idle_last", RND ? 8 : 7, 2, 0);

    // Mid-packet reset discards the partial sum.
    beat(1000, 1'b0);
    beat(1000, 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    chk("mrst.tready", int'(bus.prod_tready), 1);
    chk("mrst.tvalid", int'(bus.sum_tvalid), 0);
    beat(8, 1'b1);
    expect_result("mrst", 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
